// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : phase_timer
//  Purpose  : Free-running phase counter that flags the last cycle of a
//             2^sel_log-cycle phase.
//  Revision : 1.0  initial release
// ============================================================================
module phase_timer #(
    parameter int WIDTH     = 4,
    parameter int SEL_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [SEL_WIDTH-1:0] sel_log,
    output logic                 done
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_limit;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // When sel_log == WIDTH the shift overflows to zero and the subtraction
    // yields all ones, which is still the correct terminal value.
    assign w_limit = (WIDTH'(1) << sel_log) - WIDTH'(1);
    assign done    = (r_count == w_limit);

endmodule
`default_nettype wire

// File: rtl/led_blinker.sv
`default_nettype none
// ============================================================================
//  Module   : led_blinker
//  Purpose  : Turns a pulse-count command into N fixed-length LED blinks
//             followed by a mandatory dark gap.
//  Revision : 1.0  initial release
// ============================================================================
module led_blinker #(
    parameter int   ON_LOG      = 2,
    parameter int   OFF_LOG     = 2,
    parameter int   GAP_LOG     = 4,
    parameter int   COUNT_WIDTH = 4,
    parameter logic LED_ACTIVE  = 1'b1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   cmd_valid,
    input  logic [COUNT_WIDTH-1:0] cmd_count,
    output logic                   cmd_ready,
    output logic                   busy,
    output logic                   led_pin
);

    localparam int c_MAX_LOG0    = (ON_LOG > OFF_LOG) ? ON_LOG : OFF_LOG;
    localparam int c_MAX_LOG     = (c_MAX_LOG0 > GAP_LOG) ? c_MAX_LOG0 : GAP_LOG;
    localparam int c_TIMER_WIDTH = (c_MAX_LOG > 0) ? c_MAX_LOG : 1;
    localparam int c_SEL_WIDTH   = $clog2(c_TIMER_WIDTH + 1);

    localparam logic [c_SEL_WIDTH-1:0] c_ON_SEL  = c_SEL_WIDTH'(ON_LOG);
    localparam logic [c_SEL_WIDTH-1:0] c_OFF_SEL = c_SEL_WIDTH'(OFF_LOG);
    localparam logic [c_SEL_WIDTH-1:0] c_GAP_SEL = c_SEL_WIDTH'(GAP_LOG);

    localparam int               c_STATE_W = 2;
    localparam [c_STATE_W-1:0]   c_IDLE    = 2'd0;
    localparam [c_STATE_W-1:0]   c_ON      = 2'd1;
    localparam [c_STATE_W-1:0]   c_OFF     = 2'd2;
    localparam [c_STATE_W-1:0]   c_GAP     = 2'd3;

    logic [c_STATE_W-1:0]   r_state;
    logic [c_STATE_W-1:0]   w_next_state;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic                   r_led;
    logic [c_SEL_WIDTH-1:0] w_sel;
    logic                   w_done;
    logic                   w_clear;

    phase_timer #(
        .WIDTH     (c_TIMER_WIDTH),
        .SEL_WIDTH (c_SEL_WIDTH)
    ) u_phase_timer (
        .clock   (clock),
        .clear   (w_clear),
        .sel_log (w_sel),
        .done    (w_done)
    );

    always_comb begin
        w_next_state = r_state;
        w_sel        = c_ON_SEL;
        case (r_state)
            c_IDLE: begin
                // A zero count completes the handshake but starts nothing.
                if (cmd_valid && (cmd_count != '0)) begin
                    w_next_state = c_ON;
                end
            end
            c_ON: begin
                w_sel = c_ON_SEL;
                if (w_done) begin
                    w_next_state = (r_remaining == COUNT_WIDTH'(1)) ? c_GAP : c_OFF;
                end
            end
            c_OFF: begin
                w_sel = c_OFF_SEL;
                if (w_done) begin
                    w_next_state = c_ON;
                end
            end
            c_GAP: begin
                w_sel = c_GAP_SEL;
                if (w_done) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Timer restarts on every state entry and is parked at zero while idle.
    assign w_clear = !resetn || (r_state == c_IDLE) || (w_next_state != r_state);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= c_IDLE;
            r_remaining <= '0;
            r_led       <= ~LED_ACTIVE;
        end else begin
            r_state <= w_next_state;
            r_led   <= (w_next_state == c_ON) ? LED_ACTIVE : ~LED_ACTIVE;
            if ((r_state == c_IDLE) && cmd_valid) begin
                r_remaining <= cmd_count;
            end else if ((r_state == c_ON) && w_done) begin
                r_remaining <= r_remaining - COUNT_WIDTH'(1);
            end
        end
    end

    assign cmd_ready = (r_state == c_IDLE);
    assign busy      = (r_state != c_IDLE);
    assign led_pin   = r_led;

endmodule
`default_nettype wire
